// File: rtl/score_keeper.sv
// Score keeper for a two-player paddle game: counts points from level-style
// goal inputs, locks out scoring for a fixed time after each point, emits a
// serve pulse when play resumes and flags the winner when a player reaches
// WIN_SCORE.
module score_keeper #(
  parameter int WIN_SCORE   = 9,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p1_point,
  input  logic       p2_point,
  input  logic       new_game,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic       serve,
  output logic       game_over,
  output logic       winner
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [3:0]    WIN_VAL   = 4'(WIN_SCORE);

  typedef enum logic [1:0] {PLAY, HOLD, OVER} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    dig1_nx, dig0_nx;
  logic          serve_nx, game_over_nx, winner_nx;
  logic          p1_prev, p2_prev;
  logic          p1_ev, p2_ev;
  logic [3:0]    p1_sum, p2_sum;

  assign p1_ev  = p1_point & ~p1_prev;
  assign p2_ev  = p2_point & ~p2_prev;
  assign p1_sum = dig1 + 4'd1;
  assign p2_sum = dig0 + 4'd1;

  // Next-state and next-output logic; new_game overrides any point event.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    dig1_nx      = dig1;
    dig0_nx      = dig0;
    serve_nx     = 1'b0;
    game_over_nx = game_over;
    winner_nx    = winner;
    if (new_game) begin
      state_nx     = PLAY;
      cnt_nx       = '0;
      dig1_nx      = '0;
      dig0_nx      = '0;
      game_over_nx = 1'b0;
      winner_nx    = 1'b0;
    end else begin
      unique case (state)
        PLAY: begin
          // Exactly one scorer; a tie of edges is dropped entirely.
          if (p1_ev ^ p2_ev) begin
            if (p1_ev) dig1_nx = p1_sum;
            else       dig0_nx = p2_sum;
            if ((p1_ev && p1_sum == WIN_VAL) || (p2_ev && p2_sum == WIN_VAL)) begin
              state_nx     = OVER;
              game_over_nx = 1'b1;
              winner_nx    = p2_ev;
            end else begin
              state_nx = HOLD;
              cnt_nx   = HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state_nx = PLAY;
            serve_nx = 1'b1;
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
        OVER: ;
        default: state_nx = PLAY;
      endcase
    end
  end

  // State, outputs and edge-detect history; history resets high so a level
  // already asserted at reset release does not count as a point.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PLAY;
      cnt       <= '0;
      dig1      <= '0;
      dig0      <= '0;
      serve     <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
      p1_prev   <= 1'b1;
      p2_prev   <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      dig1      <= dig1_nx;
      dig0      <= dig0_nx;
      serve     <= serve_nx;
      game_over <= game_over_nx;
      winner    <= winner_nx;
      p1_prev   <= p1_point;
      p2_prev   <= p2_point;
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Randomized and directed bench for score_keeper against a cycle-level
// behavioural model (scores, remaining lockout cycles, game-over flag).
module tb_score_keeper;

  localparam int WIN  = 3;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset, p1_point, p2_point, new_game;
  logic [3:0] dig1, dig0;
  logic       serve, game_over, winner;

  int total = 0;
  int bad   = 0;

  // model
  int m_s1, m_s2, m_lock;
  bit m_over, m_win, m_serve, m_p1, m_p2;

  logic [10:0] obs, exp_v;
  assign obs   = {dig1, dig0, serve, game_over, winner};
  assign exp_v = {4'(m_s1), 4'(m_s2), m_serve, m_over, m_win};

  score_keeper #(.WIN_SCORE(WIN), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .p1_point(p1_point), .p2_point(p2_point),
    .new_game(new_game), .dig1(dig1), .dig0(dig0), .serve(serve),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // Reference behaviour for one rising edge with the given inputs.
  task automatic model_step(input bit r, input bit a, input bit b, input bit ng);
    bit e1, e2;
    e1 = a & ~m_p1;
    e2 = b & ~m_p2;
    m_serve = 0;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_lock = 0; m_over = 0; m_win = 0;
    end else if (ng) begin
      m_s1 = 0; m_s2 = 0; m_lock = 0; m_over = 0; m_win = 0;
    end else if (m_over) begin
      // scoring frozen until new_game
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_serve = 1;
    end else if (e1 != e2) begin
      if (e1) m_s1++; else m_s2++;
      if ((e1 ? m_s1 : m_s2) == WIN) begin
        m_over = 1;
        m_win  = e2;
      end else begin
        m_lock = HOLD;
      end
    end
    m_p1 = r ? 1'b1 : a;
    m_p2 = r ? 1'b1 : b;
  endtask

  // Drive at the falling edge, clock once, return at the next falling edge.
  task automatic cyc(input bit r, input bit a, input bit b, input bit ng);
    reset = r; p1_point = a; p2_point = b; new_game = ng;
    @(posedge clk);
    model_step(r, a, b, ng);
    @(negedge clk);
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    total++;
    if (obs !== 11'd0) begin
      bad++; $display("FAIL reset: got %h want 000", obs);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_point_hold;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    total++;
    if (dig1 !== 4'd1 || obs !== exp_v) begin
      bad++; $display("FAIL point_latency: got %h want %h dig1=%0d", obs, exp_v, dig1);
    end
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 0, 0);
      total++;
      if (serve !== (i == 4) || obs !== exp_v) begin
        bad++; $display("FAIL hold_serve c%0d: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_hold_level;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 0);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL hold_level c%0d: got %h want %h", i, obs, exp_v);
      end
    end
    total++;
    if (dig1 !== 4'd1) begin
      bad++; $display("FAIL hold_level_once: dig1 got %0d want 1", dig1);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_simultaneous;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 0);
    total++;
    if (obs !== 11'd0) begin
      bad++; $display("FAIL simultaneous: got %h want 000", obs);
    end
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    total++;
    if (dig1 !== 4'd1 || obs !== exp_v) begin
      bad++; $display("FAIL simul_still_play: got %h want %h", obs, exp_v);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_p2_win;
    int serves;
    serves = 0;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      cyc(0, 0, 1, 0);
      for (int i = 0; i < 6; i++) begin
        cyc(0, 0, 0, 0);
        if (serve === 1'b1) serves++;
        total++;
        if (obs !== exp_v) begin
          bad++; $display("FAIL p2_win p%0d c%0d: got %h want %h", p, i, obs, exp_v);
        end
      end
    end
    total++;
    if (dig0 !== 4'd3 || game_over !== 1'b1 || winner !== 1'b1 || serves != 2) begin
      bad++; $display("FAIL p2_win_final: dig0=%0d go=%b win=%b serves=%0d want 3 1 1 2",
                      dig0, game_over, winner, serves);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, i[0], i[1], 0);
      total++;
      if (obs !== {4'd0, 4'd3, 1'b0, 1'b1, 1'b1}) begin
        bad++; $display("FAIL over_ignore c%0d: got %h want 01b", i, obs);
      end
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_new_game;
    cyc(0, 0, 0, 1);
    total++;
    if (obs !== 11'd0) begin
      bad++; $display("FAIL new_game_clear: got %h want 000", obs);
    end
    cyc(0, 1, 0, 0);
    total++;
    if (dig1 !== 4'd1 || obs !== exp_v) begin
      bad++; $display("FAIL new_game_play: got %h want %h", obs, exp_v);
    end
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    total++;
    if (obs !== 11'd0) begin
      bad++; $display("FAIL new_game_point: got %h want 000", obs);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_reset_in_hold;
    int serves;
    serves = 0;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0);
    total++;
    if (obs !== 11'd0) begin
      bad++; $display("FAIL reset_in_hold: got %h want 000", obs);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 0);
      if (serve === 1'b1) serves++;
    end
    total++;
    if (obs !== 11'd0 || serves != 0) begin
      bad++; $display("FAIL reset_release: got %h serves=%0d want 000 0", obs, serves);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_random;
    bit a, b;
    a = 0; b = 0;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) a = ~a;
      if ($urandom_range(0, 3) == 0) b = ~b;
      cyc($urandom_range(0, 79) == 0, a, b, $urandom_range(0, 39) == 0);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL random c%0d: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    reset = 1; p1_point = 0; p2_point = 0; new_game = 0;
    m_s1 = 0; m_s2 = 0; m_lock = 0; m_over = 0; m_win = 0; m_serve = 0;
    m_p1 = 1; m_p2 = 1;
    @(negedge clk);
    test_reset;
    test_point_hold;
    test_hold_level;
    test_simultaneous;
    test_p2_win;
    test_new_game;
    test_reset_in_hold;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
